// File: rtl/rom_dl_sched.sv
// ROM download scheduler: turns the ioctl byte stream into acknowledged SDRAM port
// writes and PROM writes, latches core_mod, and generates the post-load core reset.
module rom_dl_sched #(
   parameter logic [24:0] SP_BASE    = 25'h30000,
   parameter logic [24:0] PROM_BASE  = 25'hA0000,
   parameter logic [24:0] ROM_END    = 25'hA0920,
   parameter logic [15:0] RST_CYCLES = 16'hFFFF
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   input  logic        user_reset,
   output logic        port1_req,
   input  logic        port1_ack,
   output logic [22:0] port1_a,
   output logic [1:0]  port1_ds,
   output logic [15:0] port1_d,
   output logic        port1_we,
   output logic        port2_req,
   input  logic        port2_ack,
   output logic [22:0] port2_a,
   output logic [1:0]  port2_ds,
   output logic [15:0] port2_d,
   output logic        port2_we,
   output logic        prom_wr,
   output logic [11:0] prom_addr,
   output logic [7:0]  prom_data,
   output logic [7:0]  core_mod,
   output logic        rom_loaded,
   output logic        reset,
   output logic        err_drop
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, FINISH} state_t;
   state_t state, state_nxt;

   logic        wr_d, dl0_d, fin_pend, use1, use2, hold;
   logic [15:0] rst_cnt;
   logic [24:0] sp_off, prom_off;
   logic        strobe, dl0, dl0_fall, dl0_rise, acks_done, accept;
   logic        go1, go2, go_prom, go_core, drop, wait_nxt, set_loaded;

   assign strobe    = ioctl_wr & ~wr_d;
   assign dl0       = ioctl_download & (ioctl_index == 8'd0);
   assign dl0_fall  = dl0_d & ~dl0;
   assign dl0_rise  = dl0 & ~dl0_d;
   assign accept    = strobe & ~ioctl_wait & dl0;
   assign drop      = strobe & ioctl_wait;
   assign sp_off    = ioctl_addr - SP_BASE;
   assign prom_off  = ioctl_addr - PROM_BASE;
   assign port1_we  = dl0;
   assign port2_we  = dl0;

   // Only ports toggled by the current transaction gate completion.
   assign acks_done = (~use1 | (port1_ack == port1_req)) &
                      (~use2 | (port2_ack == port2_req));

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt  = state;
      wait_nxt   = ioctl_wait;
      go1        = 1'b0;
      go2        = 1'b0;
      go_prom    = 1'b0;
      go_core    = 1'b0;
      set_loaded = 1'b0;
      case (state)
         IDLE: begin
            wait_nxt = 1'b0;
            go_core  = strobe & ~ioctl_wait & (ioctl_index == 8'd1) & (ioctl_addr == '0);
            if (accept) begin
               wait_nxt = 1'b1;
               if (ioctl_addr < SP_BASE) begin
                  go1       = 1'b1;
                  state_nxt = ISSUE;
               end else if (ioctl_addr < PROM_BASE) begin
                  go1       = 1'b1;
                  go2       = 1'b1;
                  state_nxt = ISSUE;
               end else if (ioctl_addr < ROM_END) begin
                  go_prom   = 1'b1;
               end
            end else if (dl0_fall || fin_pend) begin
               state_nxt = FINISH;
            end
         end
         ISSUE: state_nxt = WAIT_ACK;
         WAIT_ACK: begin
            if (acks_done) begin
               wait_nxt  = 1'b0;
               state_nxt = (dl0_fall || fin_pend) ? FINISH : IDLE;
            end
         end
         FINISH: begin
            wait_nxt   = 1'b0;
            set_loaded = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wr_d       <= 1'b0;
         dl0_d      <= 1'b0;
         fin_pend   <= 1'b0;
         use1       <= 1'b0;
         use2       <= 1'b0;
         ioctl_wait <= 1'b0;
         port1_req  <= 1'b0;
         port1_a    <= '0;
         port1_ds   <= '0;
         port1_d    <= '0;
         port2_req  <= 1'b0;
         port2_a    <= '0;
         port2_ds   <= '0;
         port2_d    <= '0;
         prom_wr    <= 1'b0;
         prom_addr  <= '0;
         prom_data  <= '0;
         core_mod   <= '0;
         rom_loaded <= 1'b0;
         err_drop   <= 1'b0;
      end else begin
         wr_d       <= ioctl_wr;
         dl0_d      <= dl0;
         ioctl_wait <= wait_nxt;
         prom_wr    <= go_prom;
         if (drop)    err_drop <= 1'b1;
         if (go_core) core_mod <= ioctl_dout;
         if (dl0_fall)                fin_pend <= 1'b1;
         else if (state == FINISH)    fin_pend <= 1'b0;
         if (dl0_rise)        rom_loaded <= 1'b0;
         else if (set_loaded) rom_loaded <= 1'b1;
         if (go1) begin
            use1      <= 1'b1;
            use2      <= go2;
            port1_req <= ~port1_req;
            port1_a   <= ioctl_addr[23:1];
            port1_ds  <= {ioctl_addr[0], ~ioctl_addr[0]};
            port1_d   <= {ioctl_dout, ioctl_dout};
         end
         if (go2) begin
            port2_req <= ~port2_req;
            port2_a   <= sp_off[23:1];
            port2_ds  <= {sp_off[0], ~sp_off[0]};
            port2_d   <= {ioctl_dout, ioctl_dout};
         end
         if (go_prom) begin
            prom_addr <= prom_off[11:0];
            prom_data <= ioctl_dout;
         end
      end
   end

   // Reload condition is registered, so reset falls RST_CYCLES + 2 clocks after rom_loaded.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         hold    <= 1'b1;
         rst_cnt <= RST_CYCLES;
         reset   <= 1'b1;
      end else begin
         hold  <= user_reset | ~rom_loaded | dl0;
         reset <= (rst_cnt != 16'd0);
         if (hold)                  rst_cnt <= RST_CYCLES;
         else if (rst_cnt != 16'd0) rst_cnt <= rst_cnt - 16'd1;
      end
   end

endmodule

// File: tb/tb_rom_dl_sched.sv
// Directed bench for rom_dl_sched: routing, handshake timing, drops, load completion, reset timing.
module tb_rom_dl_sched;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        ioctl_download, ioctl_wr, user_reset;
   logic [7:0]  ioctl_index, ioctl_dout;
   logic [24:0] ioctl_addr;
   logic        ioctl_wait;
   logic        port1_req, port1_ack, port1_we, port2_req, port2_ack, port2_we;
   logic [22:0] port1_a, port2_a;
   logic [1:0]  port1_ds, port2_ds;
   logic [15:0] port1_d, port2_d;
   logic        prom_wr, rom_loaded, reset, err_drop;
   logic [11:0] prom_addr;
   logic [7:0]  prom_data, core_mod;

   int checks = 0;
   int failures = 0;

   rom_dl_sched #(.RST_CYCLES(16'd16)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
      .user_reset(user_reset),
      .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a), .port1_ds(port1_ds),
      .port1_d(port1_d), .port1_we(port1_we),
      .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a), .port2_ds(port2_ds),
      .port2_d(port2_d), .port2_we(port2_we),
      .prom_wr(prom_wr), .prom_addr(prom_addr), .prom_data(prom_data),
      .core_mod(core_mod), .rom_loaded(rom_loaded), .reset(reset), .err_drop(err_drop)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   // Raises ioctl_wr for exactly one sampling edge; returns 1 time unit after that edge.
   task automatic strobe(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
      ioctl_index = idx;
      ioctl_addr  = addr;
      ioctl_dout  = data;
      ioctl_wr    = 1'b1;
      step();
      ioctl_wr    = 1'b0;
   endtask

   initial begin
      int busy, n, guard;
      reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
      ioctl_addr = '0; ioctl_dout = '0; user_reset = 1'b0; port1_ack = 1'b0; port2_ack = 1'b0;
      step(); step();
      check("rst_wait", ioctl_wait, 0);
      check("rst_req1", port1_req, 0);
      check("rst_req2", port2_req, 0);
      check("rst_prom_wr", prom_wr, 0);
      check("rst_core_mod", core_mod, 0);
      check("rst_loaded", rom_loaded, 0);
      check("rst_reset", reset, 1);
      check("rst_err", err_drop, 0);
      reset_n = 1'b1;
      step();

      // core_mod byte via index 1
      ioctl_download = 1'b1;
      strobe(8'd1, 25'h0, 8'h0B);
      check("cm_value", core_mod, 8'h0B);
      check("cm_wait", ioctl_wait, 0);
      check("cm_req1", port1_req, 0);
      step();
      strobe(8'd1, 25'h1, 8'hFF);
      check("cm_other_addr", core_mod, 8'h0B);
      check("cm_req2", port2_req, 0);
      ioctl_download = 1'b0; ioctl_index = 8'd0;
      step();
      ioctl_download = 1'b1;
      step();
      check("dl_not_loaded", rom_loaded, 0);

      // port1 only, ack three cycles after the request
      strobe(8'd0, 25'h00010, 8'h5A);
      busy = 1;
      check("p1_req", port1_req, 1);
      check("p1_req2_idle", port2_req, 0);
      check("p1_a", port1_a, 23'h8);
      check("p1_ds", port1_ds, 2'b01);
      check("p1_d", port1_d, 16'h5A5A);
      repeat (3) begin step(); if (ioctl_wait) busy++; end
      port1_ack = 1'b1;
      guard = 0;
      while (ioctl_wait && guard < 50) begin step(); guard++; if (ioctl_wait) busy++; end
      check("p1_wait_drop", ioctl_wait, 0);
      check("p1_busy_cycles", busy, 4);
      check("p1_req2_after", port2_req, 0);

      // sprite region: both ports, port2 acks first
      strobe(8'd0, 25'h30001, 8'hC3);
      check("sp_req1", port1_req, 0);
      check("sp_req2", port2_req, 1);
      check("sp_p1_a", port1_a, 23'h18000);
      check("sp_p1_ds", port1_ds, 2'b10);
      check("sp_p2_a", port2_a, 23'h0);
      check("sp_p2_ds", port2_ds, 2'b10);
      check("sp_p2_d", port2_d, 16'hC3C3);
      step();
      port2_ack = 1'b1;
      step();
      check("sp_wait_e2", ioctl_wait, 1);
      step();
      check("sp_wait_e3", ioctl_wait, 1);
      port1_ack = 1'b0;
      step();
      check("sp_wait_drop", ioctl_wait, 0);

      // PROM byte, then a byte past the image end
      strobe(8'd0, 25'hA0905, 8'h07);
      check("prom_wr_pulse", prom_wr, 1);
      check("prom_addr", prom_addr, 12'h905);
      check("prom_data", prom_data, 8'h07);
      check("prom_wait", ioctl_wait, 1);
      check("prom_no_req1", port1_req, 0);
      check("prom_no_req2", port2_req, 1);
      step();
      check("prom_wr_end", prom_wr, 0);
      check("prom_wait_drop", ioctl_wait, 0);
      strobe(8'd0, 25'hA0920, 8'h55);
      check("end_no_prom", prom_wr, 0);
      check("end_prom_data", prom_data, 8'h07);
      check("end_no_req1", port1_req, 0);
      step();
      check("end_wait_drop", ioctl_wait, 0);
      check("end_no_prom2", prom_wr, 0);

      // strobe while busy is dropped
      strobe(8'd0, 25'h00020, 8'h11);
      step();
      strobe(8'd0, 25'h00040, 8'h22);
      check("drop_err", err_drop, 1);
      port1_ack = 1'b1;
      guard = 0;
      while (ioctl_wait && guard < 50) begin step(); guard++; end
      check("drop_wait_done", ioctl_wait, 0);
      check("drop_req1", port1_req, 1);
      check("drop_p1_a", port1_a, 23'h10);
      check("drop_p1_d", port1_d, 16'h1111);

      // download ends with an ack outstanding
      strobe(8'd0, 25'h00050, 8'h33);
      ioctl_download = 1'b0;
      repeat (3) step();
      check("fin_pending_loaded", rom_loaded, 0);
      check("fin_pending_wait", ioctl_wait, 1);
      port1_ack = 1'b0;
      n = 0;
      while (!rom_loaded && n < 20) begin step(); n++; end
      check("fin_latency", n, 2);
      check("fin_wait", ioctl_wait, 0);
      n = 0;
      while (reset && n < 100) begin step(); n++; end
      check("fin_reset_fall", n, 18);

      // user reset pulse
      user_reset = 1'b1;
      step();
      user_reset = 1'b0;
      n = 0;
      guard = 0;
      while (!reset && guard < 10) begin step(); guard++; end
      while (reset && n < 100) begin step(); n++; end
      check("ur_reset_len_ok", n >= 16, 1);

      // a new index-0 download clears rom_loaded
      ioctl_download = 1'b1;
      step();
      check("new_dl_clear", rom_loaded, 0);

      // reset_n mid-transaction
      strobe(8'd0, 25'h00060, 8'h44);
      check("mid_req1", port1_req, 1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_req1", port1_req, 0);
      check("mid_rst_wait", ioctl_wait, 0);
      check("mid_rst_err", err_drop, 0);
      check("mid_rst_reset", reset, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
